seq_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the execute stage of pipeline_rv32i. Execute launches it with a one-cycle start pulse. Its busy output feeds hazard_detection to stall the front end. Its done/result pair feeds the EX/MEM register toward writeback. Division-by-zero and signed-overflow cases are resolved on a one-cycle fast path.

---
 rtl/seq_divider_if.sv | 37 +++
 rtl/seq_divider.sv | 154 +++++++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// ----------------------------------------------------------------------------
// seq_divider_if
//   Request/response bundle between the execute stage and seq_divider.
//
//   start  : one-cycle launch request (execute -> divider)
//   op     : funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1    : dividend
//   rs2    : divisor
//   flush  : synchronous abort from branch/hazard logic
//   busy   : high while an iterative division is running (divider -> core)
//   done   : one-cycle pulse, result valid in the same cycle
//   result : quotient or remainder, held until the next done
//
//   master : execute-stage side; slave : divider side.
// ----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. One quotient bit
//   is produced per cycle on operand magnitudes; signs are reapplied on the
//   edge that enters FIN. Divide-by-zero and signed overflow (MIN / -1)
//   bypass the iteration and go straight to FIN.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : seq_divider_if slave modport (start/op/rs1/rs2/flush in,
//            busy/done/result out)
//
//   done is registered and is high exactly while the FSM sits in FIN.
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic [1:0]      op_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic            fits;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] final_d;
    logic            is_signed;
    logic            div_zero;
    logic            sovf;

    // Two's-complement magnitude of a signed operand; MIN maps to 2^(XLEN-1),
    // which is still representable as an unsigned XLEN-bit value.
    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                   input logic            neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    assign is_signed = ~bus.op[0];
    assign div_zero  = (bus.rs2 == '0);
    assign sovf      = is_signed && (bus.rs1 == MIN_S) && (bus.rs2 == '1);

    // The shifted partial remainder needs XLEN+1 bits: with an unsigned
    // divisor above 2^(XLEN-1) it can exceed XLEN bits before subtraction.
    // The top bit of the difference is the borrow.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvsr_q};
        fits     = ~rem_diff[XLEN];
        rem_d    = fits ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_d    = {quo_q[XLEN-2:0], fits};
        final_d  = op_q[1] ? apply_sign(rem_d, neg_rem_q)
                           : apply_sign(quo_d, neg_quo_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                // Abort wins over start and over FIN; result is left as is.
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (div_zero) begin
                                result_q <= bus.op[1] ? bus.rs1 : '1;
                                done_q   <= 1'b1;
                                state_q  <= FIN;
                            end else if (sovf) begin
                                result_q <= bus.op[1] ? '0 : MIN_S;
                                done_q   <= 1'b1;
                                state_q  <= FIN;
                            end else begin
                                op_q      <= bus.op;
                                neg_quo_q <= is_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                                neg_rem_q <= is_signed & bus.rs1[XLEN-1];
                                quo_q     <= is_signed ? abs_val(bus.rs1) : bus.rs1;
                                dvsr_q    <= is_signed ? abs_val(bus.rs2) : bus.rs2;
                                rem_q     <= '0;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            result_q <= final_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= FIN;
                        end
                    end
                    FIN: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Directed bench for seq_divider (XLEN=32). Expected values are worked out
//   by hand from RV32M semantics. Latency k counts falling edges after the
//   launch edge: fast path k=1, iterative path k=33 with 32 busy cycles.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    seq_divider_if #(.XLEN(XLEN)) bus();

    seq_divider #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation and watch 45 cycles: latency, done count,
    // busy cycle count and the captured result.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int ndone;
        int nbusy;
        logic [31:0] got;
        lat = -1; ndone = 0; nbusy = 0; got = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.rs1 = a; bus.rs2 = b;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.rs1   = $urandom;
                bus.rs2   = $urandom;
            end
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    got = bus.result;
                end
            end
        end
        check({tag, "_result"}, got, exp);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        check({tag, "_nbusy"}, 32'(nbusy), (exp_lat == 1) ? 32'd0 : 32'd32);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
        bus.rs1 = '0; bus.rs2 = '0;

        // Reset state
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned iterative path
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);

        // Signed iterative path
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);

        // Signed overflow fast path
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Divide-by-zero fast path
        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1);

        // Flush mid-iteration: busy drops, no done, result keeps 5
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) ndone++;
        end
        check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("flush_ndone", 32'(ndone), 32'd0);
        check("flush_result_hold", bus.result, 32'd5);

        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // Start pulses during BUSY and during FIN are both ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs1 = 32'd50; bus.rs2 = 32'd5;
        ndone = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 5) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.rs1 = 32'd7; bus.rs2 = 32'd7;
            end
            if (bus.done) begin
                ndone++;
                check("ign_result", bus.result, 32'd10);
                bus.start = 1'b1; bus.op = 2'b01; bus.rs1 = 32'd20; bus.rs2 = 32'd4;
                @(negedge clk);
                bus.start = 1'b0;
                check("ign_fin_busy", {31'd0, bus.busy}, 32'd0);
                check("ign_fin_done", {31'd0, bus.done}, 32'd0);
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_result_hold", bus.result, 32'd10);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
